mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/lib_pkg.sv | 25 ++
 rtl/mem_access_unit_if.sv | 15 +
 rtl/mem_lane_align.sv | 49 ++++
 rtl/mem_access_unit.sv | 115 +++++++++++
 tb/tb_mem_access_unit.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/lib_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 size codes
// and strobe width.
package lib_pkg;

  localparam int STRB_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Sign variants share the size of their signed twin; unknown codes fall to word.
  function automatic size_t size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_of = SZ_B;
      F3_H, F3_HU: size_of = SZ_H;
      default:     size_of = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the load/store unit; master = unit, slave = memory.
interface mem_access_unit_if #(parameter int WIDTH = 32);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [3:0]       mem_wstrb;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment: store strobes/data up into lanes, load data
// down to bit 0 with upper bits cleared.
module mem_lane_align
  import lib_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  size_t            size,
  input  logic [1:0]       offset,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [3:0]       wstrb,
  output logic [WIDTH-1:0] wdata_lane,
  output logic [WIDTH-1:0] rdata_align
);

  logic [1:0] lane;
  logic [4:0] sh;

  always_comb begin
    lane        = 2'b00;
    wstrb       = 4'b1111;
    wdata_lane  = wdata;
    rdata_align = mem_rdata;
    case (size)
      SZ_B: begin
        lane        = offset;
        wstrb       = 4'b0001 << lane;
        wdata_lane  = {{(WIDTH-8){1'b0}}, wdata[7:0]} << {lane, 3'b000};
        rdata_align = (mem_rdata >> {lane, 3'b000}) & {{(WIDTH-8){1'b0}}, 8'hFF};
      end
      SZ_H: begin
        // Halfwords only ever sit on lane 0 or 2; addr[0] is dropped here.
        lane        = {offset[1], 1'b0};
        wstrb       = 4'b0011 << lane;
        wdata_lane  = {{(WIDTH-16){1'b0}}, wdata[15:0]} << {lane, 3'b000};
        rdata_align = (mem_rdata >> {lane, 3'b000}) & {{(WIDTH-16){1'b0}}, 16'hFFFF};
      end
      default: ;
    endcase
  end

  assign sh = {lane, 3'b000};

  // sh is kept for readability in waveforms; it mirrors the shift above.
  logic unused_sh;
  assign unused_sh = ^sh;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time from execute, IDLE -> REQ -> DONE.
// Optional MEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into an error pulse.
module mem_access_unit
  import lib_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              load,
  input  logic [2:0]        funct3,
  input  logic [WIDTH-1:0]  addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              done,
  output logic              busy,
  output logic              misaligned,
  mem_access_unit_if.master mem
);

  state_t     state, next;
  size_t      size_in, size_q, al_size;
  logic       load_q, mis_now;
  logic [1:0] off_q, al_off;
  logic [3:0]       al_wstrb;
  logic [WIDTH-1:0] al_wdata, al_rdata;

  assign size_in = size_of(funct3);

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;
  assign mis_now = (size_in == SZ_H && addr[0]) || (size_in == SZ_W && addr[1:0] != 2'b00);
`else
  assign mis_now = 1'b0;
`endif

  // The aligner sees the live request in IDLE (store lanes) and the latched one in REQ (load lanes).
  assign al_size = (state == S_IDLE) ? size_in : size_q;
  assign al_off  = (state == S_IDLE) ? addr[1:0] : off_q;

  mem_lane_align #(.WIDTH(WIDTH)) u_align (
    .size        (al_size),
    .offset      (al_off),
    .wdata       (wdata),
    .mem_rdata   (mem.mem_rdata),
    .wstrb       (al_wstrb),
    .wdata_lane  (al_wdata),
    .rdata_align (al_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  always_comb begin
    next       = state;
    done       = 1'b0;
    busy       = 1'b1;
    misaligned = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (valid) next = mis_now ? S_DONE : S_REQ;
      end
      S_REQ:  if (mem.mem_ready) next = S_DONE;
      S_DONE: begin
        done = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = mis_q;
`endif
        next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q        <= 1'b0;
      size_q        <= SZ_W;
      off_q         <= 2'b00;
      rdata         <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wstrb <= 4'b0000;
      mem.mem_wdata <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q         <= 1'b0;
`endif
    end else if (state == S_IDLE && valid) begin
      load_q <= load;
      size_q <= size_in;
      off_q  <= addr[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q  <= mis_now;
`endif
      if (!mis_now) begin
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= !load;
        mem.mem_addr  <= {addr[WIDTH-1:2], 2'b00};
        mem.mem_wstrb <= load ? 4'b0000 : al_wstrb;
        mem.mem_wdata <= load ? '0 : al_wdata;
      end
    end else if (state == S_REQ && mem.mem_ready) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_wstrb <= 4'b0000;
      if (load_q) rdata <= al_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized + directed bench for mem_access_unit against a byte-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, load = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        done, busy, misaligned;

  mem_access_unit_if #(.WIDTH(32)) bus ();

  mem_access_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid(valid), .load(load), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
    .misaligned(misaligned), .mem(bus)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: an access covers n consecutive bytes starting at lane 'start'.
  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int start_lane(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    if (n == 1) return int'(a[1:0]);
    if (n == 2) return (int'(a[1:0]) / 2) * 2;
    return 0;
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    int n = nbytes(f3);
    return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_txn(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int dly,
                         input bit poke);
    int n, st, cyc, w, exp_lat;
    bit mis, got_done, seen_req;
    logic [3:0]  e_strb;
    logic [31:0] e_wd, e_rd;
    n = nbytes(f3); st = start_lane(f3, a); mis = is_mis(f3, a);
    e_strb = '0; e_wd = '0; e_rd = '0;
    for (int i = 0; i < n; i++) begin
      e_strb[st+i]      = 1'b1;
      e_wd[8*(st+i)+:8] = wd[8*i+:8];
      e_rd[8*i+:8]      = rd[8*(st+i)+:8];
    end
    exp_lat = mis ? 1 : 2 + dly;

    @(negedge clk);
    valid = 1'b1; load = ld; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    valid = 1'b0;
    cyc = 1; w = 0; got_done = 0; seen_req = 0;
    while (cyc < 40 && !got_done) begin
      if (done) begin
        got_done = 1;
        bus.mem_ready = 1'b0;
        chk("latency", cyc, exp_lat);
        chk("misaligned", {31'b0, misaligned}, {31'b0, mis});
        chk("busy_in_done", {31'b0, busy}, 32'd1);
        if (ld && !mis) exp_rdata = e_rd;
        chk("rdata", rdata, exp_rdata);
      end else begin
        if (bus.mem_req) begin
          if (!seen_req) begin
            seen_req = 1;
            chk("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
            chk("mem_we", {31'b0, bus.mem_we}, {31'b0, !ld});
            chk("mem_wstrb", {28'b0, bus.mem_wstrb}, ld ? 32'd0 : {28'b0, e_strb});
            if (!ld) chk("mem_wdata", bus.mem_wdata, e_wd);
          end
          bus.mem_ready = (w == dly);
          bus.mem_rdata = rd;
          w++;
        end else bus.mem_ready = 1'b0;
        if (poke) begin
          valid = (cyc == 1);
          load = ~ld; addr = $urandom; funct3 = 3'($urandom);
        end
        @(negedge clk);
        cyc++;
      end
    end
    valid = 1'b0;
    bus.mem_ready = 1'b0;
    if (!got_done) chk("done_timeout", 32'd0, 32'd1);
    chk("mem_req_seen", {31'b0, seen_req}, {31'b0, !mis});
    @(negedge clk);
    chk("idle_after", {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    #12;
    chk("rst_outs", {27'b0, bus.mem_req, bus.mem_we, done, busy, misaligned}, 32'd0);
    chk("rst_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
    chk("rst_vecs", rdata | bus.mem_addr | bus.mem_wdata, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed: SB at top lane, LH upper half with 3 wait cycles, misaligned LW.
    run_txn(1'b0, 3'b000, 32'h1003, 32'h000000AB, 32'h0, 0, 1'b0);
    run_txn(1'b1, 3'b001, 32'h2002, 32'h0, 32'hBEEF1234, 3, 1'b0);
    run_txn(1'b1, 3'b010, 32'h2001, 32'h0, 32'h11223344, 0, 1'b0);

    // Reset in the middle of REQ aborts with everything cleared on the spot.
    @(negedge clk);
    valid = 1'b1; load = 1'b1; funct3 = 3'b010; addr = 32'h3000;
    @(negedge clk);
    valid = 1'b0;
    chk("req_before_rst", {31'b0, bus.mem_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_outs", {27'b0, bus.mem_req, bus.mem_we, done, busy, misaligned}, 32'd0);
    chk("abort_vecs", rdata | bus.mem_addr | bus.mem_wdata | {28'b0, bus.mem_wstrb}, 32'd0);
    exp_rdata = '0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("no_done_after_rst", {30'b0, done, busy}, 32'd0);
    run_txn(1'b1, 3'b100, 32'h3001, 32'h0, 32'hCAFE5A77, 1, 1'b0);

    // valid while busy is dropped; spurious mem_ready in IDLE does nothing.
    run_txn(1'b0, 3'b001, 32'h4002, 32'h00001234, 32'h0, 2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("spurious_idle", {30'b0, done, busy | bus.mem_req}, 32'd0);
    end
    bus.mem_ready = 1'b0;

    for (int t = 0; t < 40; t++)
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
